imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion of the instruction memory: receives 32-bit words from a host
//  stream (valid/ready) and writes them little-endian, one byte per cycle, into the
//  byte-addressable instruction memory. Holds the CPU off (cpu_hold) while loading,
//  and rejects misaligned or out-of-range loads before any byte is written.
// PARAMETERS
//  MEM_SIZE   256  instruction memory size in bytes; must match the memory instance
//  CNT_W      16   width of word_count
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      one-cycle request to begin a load; sampled only in IDLE
//  base_addr   in   32     byte address of first word; sampled with start
//  word_count  in   CNT_W  number of 32-bit words to load; sampled with start
//  s_valid     in   1      host word valid
//  s_data      in   32     host word
//  s_ready     out  1      loader accepts s_data this cycle
//  mem_we      out  1      byte write enable to instruction memory
//  mem_addr    out  32     byte write address
//  mem_wdata   out  8      byte write data
//  busy        out  1      high in every state except IDLE
//  cpu_hold    out  1      equals busy; CPU must not fetch while high
//  done        out  1      one-cycle pulse at end of a successful or empty load
//  error       out  1      sticky; set on rejected load, cleared by next accepted start
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all outputs 0; internal addr/count/word regs 0.
//    Reset mid-load aborts immediately; bytes already written stay in memory.
//  - States: IDLE, WAIT_WORD, WR_B0, WR_B1, WR_B2, WR_B3, DONE.
//  - IDLE, start=1: clear error; check base_addr[1:0]==0 and
//    base_addr + 4*word_count <= MEM_SIZE using 34-bit unsigned arithmetic (no wrap).
//      fail -> error<=1, stay IDLE, no write, no done.
//      pass, word_count==0 -> DONE.  pass, word_count>0 -> latch addr/count, WAIT_WORD.
//  - start in any state other than IDLE is ignored.
//  - WAIT_WORD: s_ready=1 (combinational from state only, never from s_valid).
//    s_valid&&s_ready: latch s_data -> WR_B0. s_valid=0: stay, no writes.
//  - WR_Bk (k=0..3): mem_we=1, mem_addr=cur_addr+k, mem_wdata=word[8k+7:8k]; s_ready=0.
//    WR_B3: cur_addr+=4, remaining-=1; remaining was 1 -> DONE, else WAIT_WORD.
//  - DONE: done=1 for exactly one cycle, busy=0 on the following cycle -> IDLE.
//  - mem_we, mem_addr, mem_wdata registered outputs; mem_we=0 outside WR_Bk, addr/data 0.
//  - Throughput: 5 cycles per word minimum (1 accept + 4 bytes); N words with s_valid
//    held high: start to done = 1 + 5N cycles.
//  - error is never set during a load; once checks pass, the load always completes.
// TESTING
//  1. MEM_SIZE=256, start base=0x00 count=2, words 0x11223344,0xAABBCCDD -> writes
//     0:44 1:33 2:22 3:11 4:DD 5:CC 6:BB 7:AA in that order; done pulse at cycle 11.
//  2. start base=0x02 count=1 -> error=1 next cycle, busy=0, mem_we never asserted.
//  3. base=252 count=2 -> error, no writes; then base=252 count=1 -> error clears,
//     writes 252..255, done pulses.
//  4. count=0 -> busy one cycle, done pulse, no s_ready, no writes.
//  5. s_valid low 7 cycles in WAIT_WORD -> s_ready stays 1, no writes; start pulsed
//     meanwhile ignored; load completes with original base/count.
//  6. rst_n low during WR_B2 -> all outputs 0 asynchronously; after release IDLE,
//     new start base=0x10 count=1 loads correctly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Host-stream, control and instruction-memory byte-write signals of the imem_loader.
// The master side is the host/control logic; the slave side is the loader itself.
interface imem_loader_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             s_valid;
  logic [31:0]      s_data;
  logic             s_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic             busy;
  logic             cpu_hold;
  logic             done;
  logic             error;

  modport master (
    output start, base_addr, word_count, s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error
  );

  modport slave (
    input  start, base_addr, word_count, s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Streams 32-bit host words into the byte-wide instruction memory, little-endian,
// one byte per cycle, holding the CPU off and rejecting bad loads up front.
module imem_loader #(
  parameter int unsigned MEM_SIZE = 256,
  parameter int unsigned CNT_W    = 16
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_WORD = 3'd1;
  localparam logic [2:0] S_WR_B0     = 3'd2;
  localparam logic [2:0] S_WR_B1     = 3'd3;
  localparam logic [2:0] S_WR_B2     = 3'd4;
  localparam logic [2:0] S_WR_B3     = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]       state,     state_nxt;
  logic [31:0]      cur_addr,  cur_addr_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [31:0]      word,      word_nxt;
  logic             error_q,   error_nxt;

  logic             mem_we_q,    mem_we_nxt;
  logic [31:0]      mem_addr_q,  mem_addr_nxt;
  logic [7:0]       mem_wdata_q, mem_wdata_nxt;

  logic [33:0]      end_addr;
  logic             load_ok;

  // 34-bit sum so a huge base or count can never wrap back into range.
  assign end_addr = {2'b00, bus.base_addr} + 34'({bus.word_count, 2'b00});
  assign load_ok  = (bus.base_addr[1:0] == 2'b00) && (end_addr <= 34'(MEM_SIZE));

  // NOTE: every variable assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    word_nxt      = word;
    error_nxt     = error_q;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          error_nxt = 1'b0;
          if (!load_ok) begin
            error_nxt = 1'b1;
          end else if (bus.word_count == '0) begin
            state_nxt = S_DONE;
          end else begin
            cur_addr_nxt  = bus.base_addr;
            remaining_nxt = bus.word_count;
            state_nxt     = S_WAIT_WORD;
          end
        end
      end
      S_WAIT_WORD: begin
        if (bus.s_valid) begin
          word_nxt  = bus.s_data;
          state_nxt = S_WR_B0;
        end
      end
      S_WR_B0: state_nxt = S_WR_B1;
      S_WR_B1: state_nxt = S_WR_B2;
      S_WR_B2: state_nxt = S_WR_B3;
      S_WR_B3: begin
        cur_addr_nxt  = cur_addr + 32'd4;
        remaining_nxt = remaining - CNT_W'(1);
        state_nxt     = (remaining == CNT_W'(1)) ? S_DONE : S_WAIT_WORD;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write port is registered: decode it from the state being entered so the
  // byte appears on the bus for exactly the cycle spent in WR_Bk.
  always_comb begin
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = '0;
    mem_wdata_nxt = '0;
    case (state_nxt)
      S_WR_B0: begin
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = cur_addr_nxt;
        mem_wdata_nxt = word_nxt[7:0];
      end
      S_WR_B1: begin
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = cur_addr_nxt + 32'd1;
        mem_wdata_nxt = word_nxt[15:8];
      end
      S_WR_B2: begin
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = cur_addr_nxt + 32'd2;
        mem_wdata_nxt = word_nxt[23:16];
      end
      S_WR_B3: begin
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = cur_addr_nxt + 32'd3;
        mem_wdata_nxt = word_nxt[31:24];
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      word        <= '0;
      error_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state       <= state_nxt;
      cur_addr    <= cur_addr_nxt;
      remaining   <= remaining_nxt;
      word        <= word_nxt;
      error_q     <= error_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
    end
  end

  // s_ready depends on state alone so the host never sees a combinational loop.
  assign bus.s_ready   = (state == S_WAIT_WORD);
  assign bus.busy      = (state != S_IDLE);
  assign bus.cpu_hold  = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.error     = error_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected byte writes are queued as words are
// driven and popped as the loader writes them; control outputs are checked inline.
module tb_imem_loader;

  localparam int unsigned MEM_SIZE = 256;
  localparam int unsigned CNT_W    = 16;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   start_cyc;
  wr_t  exp_q[$];
  logic [7:0] mem [MEM_SIZE];

  imem_loader_if #(.CNT_W(CNT_W)) bus ();

  imem_loader #(.MEM_SIZE(MEM_SIZE), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model plus scoreboard pop on every byte the loader writes.
  always @(posedge clk) begin
    if (rst_n && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(bus.mem_we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, e.addr);
        check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] base, input logic [CNT_W-1:0] count);
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = count;
    start_cyc      = cyc;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] data);
    int n;
    wr_t e;
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    n = 0;
    while (!bus.s_ready && n < 40) begin
      tick();
      n++;
    end
    check("s_ready_wait", 32'(bus.s_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      e.addr = addr + 32'(k);
      e.data = data[8*k +: 8];
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_error"}, 32'(bus.error), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 8'h00;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: two words back to back, done at start + 11.
    start_load(32'h0, 16'd2);
    check("t1_busy", 32'(bus.busy), 32'd1);
    send_word(32'h0, 32'h1122_3344);
    send_word(32'h4, 32'hAABB_CCDD);
    bus.s_valid = 1'b0;
    wait_done("t1", start_cyc + 11);
    check("t1_mem0", 32'(mem[0]), 32'h44);
    check("t1_mem3", 32'(mem[3]), 32'h11);
    check("t1_mem4", 32'(mem[4]), 32'hDD);
    check("t1_mem7", 32'(mem[7]), 32'hAA);

    // 2: misaligned base rejected.
    start_load(32'h2, 16'd1);
    check("t2_error", 32'(bus.error), 32'd1);
    check("t2_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    check("t2_error_sticky", 32'(bus.error), 32'd1);

    // 4: empty load clears error, busy one cycle, done pulse.
    start_load(32'h0, 16'd0);
    check("t4_error_clr", 32'(bus.error), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd1);
    check("t4_s_ready", 32'(bus.s_ready), 32'd0);
    wait_done("t4", start_cyc + 1);

    // 3: range check at the top of memory.
    start_load(32'd252, 16'd2);
    check("t3_error", 32'(bus.error), 32'd1);
    check("t3_busy", 32'(bus.busy), 32'd0);
    start_load(32'd252, 16'd1);
    check("t3_error_clr", 32'(bus.error), 32'd0);
    send_word(32'd252, 32'hDEAD_BEEF);
    bus.s_valid = 1'b0;
    wait_done("t3", start_cyc + 6);
    check("t3_mem255", 32'(mem[255]), 32'hDE);

    // 5: host stalls, stray start while busy is ignored.
    start_load(32'h20, 16'd1);
    for (int i = 0; i < 7; i++) begin
      check("t5_ready_hold", 32'(bus.s_ready), 32'd1);
      if (i == 3) begin
        bus.start      = 1'b1;
        bus.base_addr  = 32'h40;
        bus.word_count = 16'd3;
      end
      tick();
      bus.start = 1'b0;
    end
    send_word(32'h20, 32'h0102_0304);
    bus.s_valid = 1'b0;
    wait_done("t5", start_cyc + 13);
    tick();
    check("t5_stay_idle", 32'(bus.busy), 32'd0);

    // 6: asynchronous reset while WR_B2 is on the bus.
    start_load(32'h30, 16'd1);
    send_word(32'h30, 32'h5566_7788);
    bus.s_valid = 1'b0;
    tick();
    tick();
    check("t6_in_b2_addr", bus.mem_addr, 32'h32);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_mem30_kept", 32'(mem[8'h30]), 32'h88);
    check("t6_mem31_kept", 32'(mem[8'h31]), 32'h77);
    check("t6_mem32_none", 32'(mem[8'h32]), 32'h00);
    start_load(32'h10, 16'd1);
    send_word(32'h10, 32'hCAFE_F00D);
    bus.s_valid = 1'b0;
    wait_done("t6", start_cyc + 6);
    check("t6_mem10", 32'(mem[8'h10]), 32'h0D);
    check("t6_mem13", 32'(mem[8'h13]), 32'hCA);

    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
